// File: rtl/fir_pkg.sv
// Shared definitions for FIR output stages: default widths and the
// round-then-saturate helper used to narrow a MAC accumulator to a sample.
package fir_pkg;

  localparam int ACC_W_DEF   = 29;
  localparam int OUT_W_DEF   = 12;
  localparam int COEFF_W_DEF = 16;

  // Working width of the helper; accumulators up to 62 bits round without overflow.
  localparam int SR_W = 64;

  typedef struct packed {
    logic            sat;
    logic [SR_W-1:0] value;
  } sat_res_t;

  // Round half toward +inf, arithmetic shift right, then clamp to a signed
  // out_w-bit range. sat reports whether the clamp engaged.
  function automatic sat_res_t sat_round(input logic signed [SR_W-1:0] acc,
                                         input int shift,
                                         input int out_w);
    sat_res_t res;
    logic signed [SR_W-1:0] y;
    logic signed [SR_W-1:0] hi;
    logic signed [SR_W-1:0] lo;
    y  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res.sat   = 1'b0;
    res.value = y;
    if (y > hi) begin
      res.sat   = 1'b1;
      res.value = hi;
    end else if (y < lo) begin
      res.sat   = 1'b1;
      res.value = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Small synchronous FIFO. Head entry is visible on dout; a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module fir_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full = (level == LW'(DEPTH));
  assign dout = mem[rd_ptr];

  // Qualify requests against occupancy; full+pop still admits a push.
  always_comb begin
    do_pop  = pop && (level != '0);
    do_push = push && (!full || do_pop);
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage write; contents need no reset because level gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fir_out_stage.sv
// Output stage of the systolic FIR: realigns the last MAC accumulator with
// its sample strobe, rounds/saturates it and buffers it behind valid/ready.
// The MAC chain never stalls, so a full FIFO drops results and flags it.
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FRAC_SHIFT = 15,
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [ACC_W-1:0]              acc_in,
  output logic [OUT_W-1:0]              m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          sat_o,
  output logic                          drop_o,
  input  logic                          clear_flags,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  logic [LATENCY-1:0]    vd_sr;
  logic                  v_d;
  logic [SR_W-1:0]       acc_ext;
  sat_res_t              sr;
  logic                  unused_hi;
  logic [OUT_W-1:0]      r;
  logic                  r_valid;
  logic                  pop;
  logic                  fifo_full;
  logic [OUT_W-1:0]      fifo_dout;
  logic                  sat_evt;
  logic                  drop_evt;

  assign v_d       = vd_sr[LATENCY-1];
  assign acc_ext   = {{(SR_W-ACC_W){acc_in[ACC_W-1]}}, acc_in};
  assign sr        = sat_round(acc_ext, FRAC_SHIFT, OUT_W);
  assign unused_hi = ^sr.value[SR_W-1:OUT_W];

  assign m_tvalid  = (level_o != '0);
  assign m_tdata   = m_tvalid ? fifo_dout : '0;
  assign pop       = m_tvalid && m_tready;
  assign sat_evt   = v_d && sr.sat;
  assign drop_evt  = r_valid && fifo_full && !pop;

  // Strobe delay line matching the MAC chain latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      vd_sr <= '0;
    end else begin
      vd_sr[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vd_sr[i] <= vd_sr[i-1];
    end
  end

  // Result register: capture the narrowed accumulator when the strobe lines up.
  always_ff @(posedge clock) begin
    if (reset) begin
      r       <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= v_d;
      if (v_d) r <= sr.value[OUT_W-1:0];
    end
  end

  // Sticky status flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      sat_o  <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      if (clear_flags) begin
        sat_o  <= 1'b0;
        drop_o <= 1'b0;
      end
      if (sat_evt)  sat_o  <= 1'b1;
      if (drop_evt) drop_o <= 1'b1;
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_valid),
    .din   (r),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (level_o),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage with hand-computed expectations.
module tb_fir_out_stage;

  localparam int ACC_W = 29;
  localparam int OUT_W = 12;
  localparam int LAT   = 10;
  localparam int JUNK  = 77777777;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic signed [ACC_W-1:0] acc_in;
  logic [OUT_W-1:0]        m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic                    sat_o;
  logic                    drop_o;
  logic                    clear_flags;
  logic [2:0]              level_o;

  logic signed [ACC_W-1:0] cur_acc;
  logic signed [ACC_W-1:0] pipe [LAT];

  int n_checks = 0;
  int n_errors = 0;

  fir_out_stage #(
    .ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC_SHIFT(15), .LATENCY(LAT), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .acc_in(acc_in),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .sat_o(sat_o), .drop_o(drop_o), .clear_flags(clear_flags), .level_o(level_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; acc_in follows the strobe LAT cycles later, junk otherwise.
  task automatic step();
    @(posedge clock);
    for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = in_valid ? cur_acc : ACC_W'(JUNK);
    #1;
    acc_in = pipe[LAT-1];
  endtask

  task automatic send(input int a);
    in_valid = 1'b1;
    cur_acc  = ACC_W'(a);
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_one(input string tag, input int a, input int exp);
    int n;
    send(a);
    n = 1;
    while (!m_tvalid && n < 40) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, LAT + 2);
    check({tag, " data"}, longint'($signed(m_tdata)), exp);
    step();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; acc_in = '0; cur_acc = '0;
    m_tready = 1'b0; clear_flags = 1'b0;
    for (int i = 0; i < LAT; i++) pipe[i] = ACC_W'(JUNK);
    repeat (3) step();
    reset = 1'b0;
    check("rst tvalid", m_tvalid, 0);
    check("rst tdata", m_tdata, 0);
    check("rst sat", sat_o, 0);
    check("rst drop", drop_o, 0);
    check("rst level", level_o, 0);

    // 1: single sample, exact latency, pop
    m_tready = 1'b1;
    send(98304);
    repeat (10) step();
    check("t1 not yet valid", m_tvalid, 0);
    step();
    check("t1 valid", m_tvalid, 1);
    check("t1 data", longint'($signed(m_tdata)), 3);
    check("t1 sat", sat_o, 0);
    step();
    check("t1 popped", m_tvalid, 0);
    check("t1 level", level_o, 0);

    // 2: rounding boundaries
    expect_one("rnd +half", 16384, 1);
    expect_one("rnd below half", 16383, 0);
    expect_one("rnd -half", -16384, 0);
    expect_one("rnd below -half", -16385, -1);
    check("rnd sat", sat_o, 0);

    // 3: saturation, clear, clear colliding with set
    expect_one("sat pos", 134217728, 2047);
    check("sat flag", sat_o, 1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("sat cleared", sat_o, 0);
    send(-98304000);
    repeat (9) step();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("sat set beats clear", sat_o, 1);
    step();
    check("sat neg valid", m_tvalid, 1);
    check("sat neg data", longint'($signed(m_tdata)), -2048);
    step();

    // 4: backpressure, overflow drop, ordered drain
    m_tready = 1'b0;
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    for (int k = 1; k <= 6; k++) send(k * 32768);
    repeat (11) step();
    check("bp level", level_o, 4);
    check("bp drop", drop_o, 1);
    check("bp head held", longint'($signed(m_tdata)), 1);
    step();
    check("bp head still held", longint'($signed(m_tdata)), 1);
    m_tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("bp drain valid", m_tvalid, 1);
      check("bp drain data", longint'($signed(m_tdata)), k);
      step();
    end
    check("bp drained", m_tvalid, 0);
    check("bp drained level", level_o, 0);

    // 5: full FIFO with simultaneous push and pop
    m_tready = 1'b0;
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    for (int c = 0; c < 30; c++) begin
      m_tready = (c >= 15);
      if (c < 12) begin
        in_valid = 1'b1;
        cur_acc  = ACC_W'((c + 1) * 32768);
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 15 && c <= 23) check("full level", level_o, 4);
      if (c >= 15 && c <= 26) begin
        check("full valid", m_tvalid, 1);
        check("full seq", longint'($signed(m_tdata)), c - 14);
      end
      step();
    end
    in_valid = 1'b0;
    check("full no drop", drop_o, 0);
    check("full end empty", level_o, 0);

    // 6: reset with 3 buffered and 2 in flight
    m_tready = 1'b0;
    send(134217728);
    for (int k = 2; k <= 5; k++) send(k * 32768);
    repeat (9) step();
    check("rst6 pre level", level_o, 3);
    check("rst6 pre sat", sat_o, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst6 level", level_o, 0);
    check("rst6 tvalid", m_tvalid, 0);
    check("rst6 sat", sat_o, 0);
    check("rst6 drop", drop_o, 0);
    check("rst6 tdata", m_tdata, 0);
    m_tready = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      check("rst6 no stale", m_tvalid, 0);
    end
    expect_one("post rst", 65536, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_out_stage.md
Name: fir_out_stage

Overview:
Receiving end of the systolic FIR MAC chain. Takes the wide accumulator leaving the last MAC cell and re-aligns it with the sample strobe through a latency-matched valid delay line. Rounds and saturates the result to output width, then buffers it in a small FIFO behind a valid/ready stream interface. The MAC chain cannot stall, so backpressure is absorbed by the FIFO and overflow is reported rather than propagated.

Parameters:
ACC_W, 29, width of accumulator from last MAC cell (signed)
OUT_W, 12, output sample width (signed)
FRAC_SHIFT, 15, right-shift applied to accumulator (coefficient fraction bits); must be >= 1
LATENCY, 10, cycles from in_valid to matching acc_in at chain end; must be >= 1
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  strobe asserted with each sample entering MAC chain b_in
acc_in  in  ACC_W  c_out of last MAC cell, signed
m_tdata  out  OUT_W  rounded/saturated sample, signed
m_tvalid  out  1  m_tdata valid
m_tready  in  1  downstream accepts
sat_o  out  1  sticky: at least one result saturated
drop_o  out  1  sticky: at least one result dropped (FIFO full)
clear_flags  in  1  clears sat_o and drop_o
level_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock. All state updates on posedge clock.
- Reset: delay line cleared, result register invalid, FIFO empty. m_tvalid=0, m_tdata=0, sat_o=0, drop_o=0, level_o=0. Reset mid-stream discards all in-flight and buffered samples. Nothing pre-reset emerges afterwards.
- Valid delay line: LATENCY-stage shift register fed by in_valid. Its output v_d marks the cycle in which acc_in is sampled.
- Stage R (1 cycle): when v_d=1, register r = sat(round(acc_in)) and r_valid=1; otherwise r_valid=0.
- round(x): computed in ACC_W+1 bits, (x + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. Arithmetic shift; half rounds toward +inf.
- sat(y): clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Set sat_o when a clamp occurs on a valid result.
- Push: r_valid=1 pushes r into the FIFO, same edge as the pop decision.
- Pop: m_tvalid && m_tready.
- FIFO: m_tdata is the head entry, m_tvalid = (level != 0). m_tdata is held stable while m_tvalid && !m_tready.
- Latency: in_valid at cycle t gives a sampled acc at t+LATENCY, r at t+LATENCY+1, and m_tvalid at t+LATENCY+2 when the FIFO was empty.
- Full and push without pop: the new result is dropped, drop_o=1, and FIFO contents are unchanged.
- Full and push with pop in the same cycle: both occur, level unchanged, no drop.
- Empty and push: no same-cycle bypass; the data appears one cycle later.
- Pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses level, not pointers alone.
- clear_flags in the same cycle as a new saturation/drop event: the set wins, and the flag reads 1 next cycle.
- m_tvalid never depends combinationally on m_tready.

Decomposition:
- Package fir_pkg: ACC_W/OUT_W/COEFF_W defaults, and a function sat_round(acc, shift) returning {sat_flag, value}, shared with any future decimator output stage.
- One sub-module: fir_sync_fifo (parameterised width/depth, push/pop/level, no drop logic). Drop and flag logic stays in fir_out_stage.

Test Plan:
1. Defaults. Single in_valid at cycle 0, acc_in=98304 at cycle 10 -> m_tdata=3, m_tvalid rises at cycle 12, m_tready=1 and it pops; sat_o=0.
2. Rounding. acc_in=16384 -> 1; acc_in=16383 -> 0; acc_in=-16384 -> 0; acc_in=-16385 -> -1.
3. Saturation. acc_in=134217728 -> 2047, sat_o=1; acc_in=-98304000 -> -2048. Then clear_flags -> sat_o=0 next cycle.
4. Backpressure. m_tready=0, 6 consecutive valid samples (acc=k*32768, k=1..6) -> level_o=4, drop_o=1. Release m_tready -> outputs 1,2,3,4 in order.
5. Full with simultaneous push/pop. Level=4, m_tready=1, continuous in_valid -> no drop, level stays 4, sequence is contiguous.
6. Reset mid-operation. Assert reset with 3 buffered and 2 in flight -> level_o=0, m_tvalid=0, flags=0. No stale output appears within LATENCY+3 cycles after release.
